// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and load/store type encodings for the MEM-stage
// data-memory sequencer and the load/store merge unit (mrwu).
//   dmem_state_t : sequencer FSM states
//   LS_*         : one-hot LSTypeM encodings
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR
   } dmem_state_t;

   localparam logic [4:0] LS_B  = 5'b10000;
   localparam logic [4:0] LS_H  = 5'b01000;
   localparam logic [4:0] LS_W  = 5'b00100;
   localparam logic [4:0] LS_BU = 5'b00010;
   localparam logic [4:0] LS_HU = 5'b00001;

   // Sub-word stores must read the old word before writing the merged one.
   function automatic logic is_subword_store(input logic [4:0] ls);
      return (ls == LS_B) || (ls == LS_H);
   endfunction

endpackage

// File: rtl/mem_wdog.sv
// mem_wdog: wait-cycle watchdog for one memory phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (phase entry)
//   tick       : one more cycle spent waiting for MemReady
//   expire     : count has reached TIMEOUT_CYCLES (never when TIMEOUT_CYCLES=0)
module mem_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt;

   // Saturates at LIMIT so expire stays asserted until the phase is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick && (cnt != LIMIT)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/dmem_rmw_seq.sv
// dmem_rmw_seq: MEM-stage data-memory sequencer. Loads are a read phase,
// full-word stores a write phase, sb/sh a read phase followed by a write of
// the word merged by mrwu. Stalls the pipeline until the access completes,
// aborts with a one-cycle MemErrM pulse on a memory timeout.
//   MemReqM/MemWriteM/LSTypeM/ALUResultM/WriteDataM : pipeline request (held by stall)
//   ReadDataM  : captured (or bypassed) memory word to mrwu
//   StallM     : freeze IF..MEM, low in the completion cycle
//   MemErrM    : access aborted by timeout
//   MemAddr/MemRe/MemWe/MemWData/MemRData/MemReady : memory handshake
module dmem_rmw_seq
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [4:0]  LSTypeM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        MemErrM,
   output logic [31:0] MemAddr,
   output logic        MemRe,
   output logic        MemWe,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   input  logic        MemReady
);

   dmem_state_t state, state_next;
   logic [31:0] rdata_q;
   logic        capture;
   logic        clear_rd;
   logic        expire;
   logic        wd_clr;
   logic        wd_tick;

   // Counter restarts whenever a phase is (re)entered; IDLE keeps it clear.
   assign wd_clr  = (state == IDLE) || (state_next != state);
   assign wd_tick = (state != IDLE) && !MemReady;

   mem_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr),
      .tick   (wd_tick),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (capture) begin
         rdata_q <= MemRData;
      end else if (clear_rd) begin
         rdata_q <= '0;
      end
   end

   always_comb begin
      state_next = state;
      StallM     = 1'b0;
      MemErrM    = 1'b0;
      MemRe      = 1'b0;
      MemWe      = 1'b0;
      MemAddr    = '0;
      MemWData   = '0;
      ReadDataM  = rdata_q;
      capture    = 1'b0;
      clear_rd   = 1'b0;

      unique case (state)
         IDLE: begin
            if (MemReqM) begin
               StallM = 1'b1;
               if (!MemWriteM || is_subword_store(LSTypeM)) begin
                  state_next = RD;
               end else begin
                  state_next = WR;
               end
            end
         end

         RD: begin
            if (!MemReqM) begin
               state_next = IDLE;
            end else if (MemReady) begin
               MemRe     = 1'b1;
               MemAddr   = ALUResultM;
               capture   = 1'b1;
               ReadDataM = MemRData;
               if (MemWriteM) begin
                  StallM     = 1'b1;
                  state_next = WR;
               end else begin
                  state_next = IDLE;
               end
            end else if (expire) begin
               // Abort: strobe drops in this cycle, so a pending sb/sh never writes.
               MemErrM    = 1'b1;
               clear_rd   = 1'b1;
               state_next = IDLE;
            end else begin
               MemRe   = 1'b1;
               MemAddr = ALUResultM;
               StallM  = 1'b1;
            end
         end

         WR: begin
            if (!MemReqM) begin
               state_next = IDLE;
            end else if (MemReady) begin
               MemWe      = 1'b1;
               MemAddr    = ALUResultM;
               MemWData   = WriteDataM;
               state_next = IDLE;
            end else if (expire) begin
               MemErrM    = 1'b1;
               clear_rd   = 1'b1;
               state_next = IDLE;
            end else begin
               MemWe    = 1'b1;
               MemAddr  = ALUResultM;
               MemWData = WriteDataM;
               StallM   = 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase

      // Outputs go quiet the instant reset asserts, even if MemReqM is still high.
      if (!rst_n) begin
         StallM   = 1'b0;
         MemErrM  = 1'b0;
         MemRe    = 1'b0;
         MemWe    = 1'b0;
         MemAddr  = '0;
         MemWData = '0;
      end
   end

endmodule

// File: tb/tb_dmem_rmw_seq.sv
// tb_dmem_rmw_seq: directed bench for dmem_rmw_seq with a simple memory model
// (programmable ready delay / stuck-not-ready) and an mrwu stand-in that
// merges a byte into the captured word. Memory handshakes are checked against
// a queue of expected transactions.
module tb_dmem_rmw_seq;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemReqM, MemWriteM;
   logic [4:0]  LSTypeM;
   logic [31:0] ALUResultM, WriteDataM, ReadDataM;
   logic        StallM, MemErrM;
   logic [31:0] MemAddr, MemWData, MemRData;
   logic        MemRe, MemWe, MemReady;

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t exp_q[$];

   int n_pass = 0, n_total = 0, n_fail = 0;
   int re_cyc = 0, we_cyc = 0, ovl = 0, err_cyc = 0, addr_bad = 0;

   logic        merge = 1'b0;
   logic [31:0] wdata_val = '0;
   logic [31:0] mem_rdata = '0;
   int          ready_delay = 0;
   logic        ready_stuck = 1'b0;
   int          wait_cnt = 0;

   dmem_rmw_seq #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemReqM    (MemReqM),
      .MemWriteM  (MemWriteM),
      .LSTypeM    (LSTypeM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .MemErrM    (MemErrM),
      .MemAddr    (MemAddr),
      .MemRe      (MemRe),
      .MemWe      (MemWe),
      .MemWData   (MemWData),
      .MemRData   (MemRData),
      .MemReady   (MemReady)
   );

   // mrwu stand-in: byte store merged into lane 0 of the captured word.
   always_comb WriteDataM = merge ? {ReadDataM[31:8], wdata_val[7:0]} : wdata_val;

   assign MemRData = mem_rdata;
   assign MemReady = (MemRe || MemWe) && !ready_stuck && (wait_cnt >= ready_delay);

   always @(posedge clk) begin
      if ((MemRe || MemWe) && !MemReady) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Monitor: cycle statistics plus scoreboard pop on every completed strobe.
   always @(negedge clk) begin : mon
      txn_t t;
      if (MemRe) re_cyc++;
      if (MemWe) we_cyc++;
      if (MemRe && MemWe) ovl++;
      if (MemErrM) err_cyc++;
      if (MemWe && ((MemAddr !== ALUResultM) || (MemWData !== WriteDataM))) addr_bad++;
      if ((MemRe || MemWe) && MemReady) begin
         chk("sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("sb_we", 32'(MemWe), 32'(t.we));
            chk("sb_addr", MemAddr, t.addr);
            chk("sb_data", MemWe ? MemWData : ReadDataM, t.data);
         end
      end
   end

   task automatic run_op(input logic we, input logic [4:0] ls, input logic [31:0] addr,
                         input logic [31:0] wd, input logic mg, input logic hold,
                         output int stalls, output logic err, output logic [31:0] rd);
      logic done;
      MemReqM    = 1'b1;
      MemWriteM  = we;
      LSTypeM    = ls;
      ALUResultM = addr;
      wdata_val  = wd;
      merge      = mg;
      stalls     = 0;
      done       = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!StallM) begin
            done = 1'b1;
            break;
         end
         stalls++;
      end
      chk("op_done", 32'(done), 32'd1);
      err = MemErrM;
      rd  = ReadDataM;
      @(posedge clk);
      #1;
      if (!hold) MemReqM = 1'b0;
      merge = 1'b0;
   endtask

   initial begin
      int          st;
      logic        er;
      logic [31:0] rd;
      int          we0, re0, err0, bad0, ovl0;

      rst_n = 1'b0;
      MemReqM = 1'b1;
      MemWriteM = 1'b0;
      LSTypeM = LS_W;
      ALUResultM = 32'h0000_0010;

      // Reset state: outputs quiet even with a request pending.
      #12;
      chk("rst_stall", 32'(StallM), 32'd0);
      chk("rst_re", 32'(MemRe), 32'd0);
      chk("rst_we", 32'(MemWe), 32'd0);
      chk("rst_err", 32'(MemErrM), 32'd0);
      chk("rst_rdata", ReadDataM, 32'd0);
      chk("rst_addr", MemAddr, 32'd0);
      MemReqM = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: lw, ready tied high
      we0 = we_cyc;
      mem_rdata = 32'hDEAD_BEEF;
      exp_q.push_back('{1'b0, 32'h0000_0010, 32'hDEAD_BEEF});
      run_op(1'b0, LS_W, 32'h0000_0010, 32'h0, 1'b0, 1'b0, st, er, rd);
      chk("t1_stall", 32'(st), 32'd1);
      chk("t1_rdata", rd, 32'hDEAD_BEEF);
      chk("t1_no_we", 32'(we_cyc - we0), 32'd0);
      chk("t1_no_err", 32'(er), 32'd0);

      // 2: sb, read-merge-write
      mem_rdata = 32'h1122_3344;
      exp_q.push_back('{1'b0, 32'h0000_0020, 32'h1122_3344});
      exp_q.push_back('{1'b1, 32'h0000_0020, 32'h1122_33AB});
      run_op(1'b1, LS_B, 32'h0000_0020, 32'h0000_00AB, 1'b1, 1'b0, st, er, rd);
      chk("t2_stall", 32'(st), 32'd2);
      chk("t2_hold_rdata", ReadDataM, 32'h1122_3344);

      // 4: sh with memory stuck not-ready -> timeout in RD
      ready_stuck = 1'b1;
      we0 = we_cyc;
      err0 = err_cyc;
      run_op(1'b1, LS_H, 32'h0000_0024, 32'h0000_5566, 1'b1, 1'b0, st, er, rd);
      chk("t4_stall", 32'(st), 32'd5);
      chk("t4_err", 32'(er), 32'd1);
      @(negedge clk);
      chk("t4_err_pulse", 32'(err_cyc - err0), 32'd1);
      chk("t4_no_we", 32'(we_cyc - we0), 32'd0);
      chk("t4_rdata_clr", ReadDataM, 32'd0);
      chk("t4_idle", 32'(StallM), 32'd0);
      ready_stuck = 1'b0;
      @(posedge clk);
      #1;

      // 3: sw, ready delayed 3 cycles
      ready_delay = 3;
      we0 = we_cyc;
      re0 = re_cyc;
      bad0 = addr_bad;
      exp_q.push_back('{1'b1, 32'h0000_0030, 32'h0BAD_F00D});
      run_op(1'b1, LS_W, 32'h0000_0030, 32'h0BAD_F00D, 1'b0, 1'b0, st, er, rd);
      chk("t3_stall", 32'(st), 32'd4);
      chk("t3_we_cycles", 32'(we_cyc - we0), 32'd4);
      chk("t3_no_re", 32'(re_cyc - re0), 32'd0);
      chk("t3_stable", 32'(addr_bad - bad0), 32'd0);

      // 5: reset asserted during the WR phase of an sb
      ready_delay = 2;
      mem_rdata = 32'hCAFE_F00D;
      exp_q.push_back('{1'b0, 32'h0000_0050, 32'hCAFE_F00D});
      MemReqM = 1'b1;
      MemWriteM = 1'b1;
      LSTypeM = LS_B;
      ALUResultM = 32'h0000_0050;
      wdata_val = 32'h0000_00EE;
      merge = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (MemWe) break;
      end
      chk("t5_in_wr", 32'(MemWe), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_we_drop", 32'(MemWe), 32'd0);
      chk("t5_stall_drop", 32'(StallM), 32'd0);
      MemReqM = 1'b0;
      merge = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t5_idle_stall", 32'(StallM), 32'd0);
      chk("t5_idle_re", 32'(MemRe), 32'd0);
      chk("t5_rdata", ReadDataM, 32'd0);
      ready_delay = 0;
      @(posedge clk);
      #1;
      mem_rdata = 32'h0102_0304;
      exp_q.push_back('{1'b0, 32'h0000_0054, 32'h0102_0304});
      run_op(1'b0, LS_W, 32'h0000_0054, 32'h0, 1'b0, 1'b0, st, er, rd);
      chk("t5_lw_stall", 32'(st), 32'd1);
      chk("t5_lw_rdata", rd, 32'h0102_0304);

      // 6: lw then sw back-to-back, MemReqM held
      ovl0 = ovl;
      mem_rdata = 32'h0A0B_0C0D;
      exp_q.push_back('{1'b0, 32'h0000_0060, 32'h0A0B_0C0D});
      exp_q.push_back('{1'b1, 32'h0000_0064, 32'h7777_8888});
      run_op(1'b0, LS_W, 32'h0000_0060, 32'h0, 1'b0, 1'b1, st, er, rd);
      chk("t6_lw_stall", 32'(st), 32'd1);
      chk("t6_lw_rdata", rd, 32'h0A0B_0C0D);
      run_op(1'b1, LS_W, 32'h0000_0064, 32'h7777_8888, 1'b0, 1'b0, st, er, rd);
      chk("t6_sw_stall", 32'(st), 32'd1);
      chk("t6_no_overlap", 32'(ovl - ovl0), 32'd0);

      @(negedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("never_overlap", 32'(ovl), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
